// File: rtl/core_mem_pkg.sv
// Shared definitions for the data-side memory controller: access sizes, MMIO offsets
// and the lane/alignment helpers used by the decode logic.
package core_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [5:0] MMIO_TOHOST   = 6'h00;
    localparam logic [5:0] MMIO_MTIME_LO = 6'h04;
    localparam logic [5:0] MMIO_MTIME_HI = 6'h08;

    typedef enum logic [1:0] {
        SelNone,
        SelRam,
        SelMmio
    } rsp_sel_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  byte_en = 4'b0001 << off;
            SIZE_H:  byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
module dmem_sram_bank #(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_en,
    input  logic [3:0]                     i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    mem_q[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/core_dmem_ctrl.sv
// Data memory controller: RAM plus TOHOST/MTIME MMIO window, fixed one-cycle response
// latency, right-aligned zero-filled load data.
module core_dmem_ctrl
    import core_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_data_addr,
    input  logic [XLEN-1:0] i_data_wr_data,
    input  logic [1:0]      i_data_mask,
    input  logic            i_data_wr_en,
    input  logic            i_data_req,
    output logic [XLEN-1:0] o_data_rd_data,
    output logic            o_data_ack,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_tohost,
    output logic            o_tohost_valid
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [1:0]  size;
    logic [1:0]  off;
    logic [5:0]  mmio_off;
    logic        is_mmio;
    logic        mis_now;
    logic        ram_wr;
    logic        mmio_wr;
    logic [31:0] wdata_rep;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;
    logic [31:0] rd_shift;
    logic [63:0] mtime_d;
    rsp_sel_e    sel_d;

    logic        ack_q;
    logic        mis_q;
    rsp_sel_e    sel_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic [31:0] mmio_rdata_q;
    logic [31:0] tohost_q;
    logic        tohost_valid_q;
    logic [63:0] mtime_q;

    assign size     = (i_data_mask == 2'b11) ? SIZE_W : i_data_mask;
    assign off      = i_data_addr[1:0];
    assign mmio_off = i_data_addr[5:0];
    assign is_mmio  = (i_data_addr[31:6] == MMIO_BASE[31:6]);
    // MMIO registers are word-only, so any narrower access there is rejected like misalignment.
    assign mis_now  = misaligned(size, off) || (is_mmio && size != SIZE_W);
    assign ram_wr   = i_data_req && !mis_now && i_data_wr_en && !is_mmio;
    assign mmio_wr  = i_data_req && !mis_now && i_data_wr_en && is_mmio;

    always_comb begin
        case (size)
            SIZE_B:  wdata_rep = {4{i_data_wr_data[7:0]}};
            SIZE_H:  wdata_rep = {2{i_data_wr_data[15:0]}};
            default: wdata_rep = i_data_wr_data;
        endcase
    end

    dmem_sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .i_clk  (i_clk),
        .i_en   (i_data_req),
        .i_be   (ram_wr ? byte_en(size, off) : 4'b0000),
        .i_addr (i_data_addr[AW+1:2]),
        .i_wdata(wdata_rep),
        .o_rdata(ram_rdata)
    );

    always_comb begin
        case (mmio_off)
            MMIO_TOHOST:   mmio_rdata = tohost_q;
            MMIO_MTIME_LO: mmio_rdata = mtime_q[31:0];
            MMIO_MTIME_HI: mmio_rdata = mtime_q[63:32];
            default:       mmio_rdata = '0;
        endcase
    end

    always_comb begin
        mtime_d = mtime_q + 64'd1;
        if (mmio_wr && mmio_off == MMIO_MTIME_LO) begin
            mtime_d = {mtime_q[63:32], i_data_wr_data};
        end else if (mmio_wr && mmio_off == MMIO_MTIME_HI) begin
            mtime_d = {i_data_wr_data, mtime_q[31:0]};
        end
    end

    always_comb begin
        if (!i_data_req || mis_now || i_data_wr_en) begin
            sel_d = SelNone;
        end else if (is_mmio) begin
            sel_d = SelMmio;
        end else begin
            sel_d = SelRam;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q          <= 1'b0;
            mis_q          <= 1'b0;
            sel_q          <= SelNone;
            off_q          <= 2'b00;
            size_q         <= SIZE_B;
            mmio_rdata_q   <= '0;
            tohost_q       <= '0;
            tohost_valid_q <= 1'b0;
            mtime_q        <= '0;
        end else begin
            ack_q          <= i_data_req;
            mis_q          <= i_data_req && mis_now;
            sel_q          <= sel_d;
            off_q          <= off;
            size_q         <= size;
            mmio_rdata_q   <= mmio_rdata;
            mtime_q        <= mtime_d;
            tohost_valid_q <= mmio_wr && mmio_off == MMIO_TOHOST;
            if (mmio_wr && mmio_off == MMIO_TOHOST) begin
                tohost_q <= i_data_wr_data;
            end
        end
    end

    assign rd_shift = ram_rdata >> {off_q, 3'b000};

    always_comb begin
        case (sel_q)
            SelRam: begin
                case (size_q)
                    SIZE_B:  o_data_rd_data = {24'b0, rd_shift[7:0]};
                    SIZE_H:  o_data_rd_data = {16'b0, rd_shift[15:0]};
                    default: o_data_rd_data = rd_shift;
                endcase
            end
            SelMmio: o_data_rd_data = mmio_rdata_q;
            default: o_data_rd_data = '0;
        endcase
    end

    assign o_data_ack     = ack_q;
    assign o_misaligned   = mis_q;
    assign o_tohost       = tohost_q;
    assign o_tohost_valid = tohost_valid_q;

endmodule

// File: tb/tb_core_dmem_ctrl.sv
// Self-checking bench for core_dmem_ctrl: byte-level reference model plus directed vectors.
module tb_core_dmem_ctrl;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned BYTES = DEPTH * 4;
    localparam logic [31:0] MMIO  = 32'h8000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr  = '0;
    logic [31:0] wd    = '0;
    logic [1:0]  mask  = 2'b10;
    logic        we    = 1'b0;
    logic        req   = 1'b0;
    logic [31:0] rd_data;
    logic        ack;
    logic        mis;
    logic [31:0] tohost;
    logic        tohost_valid;

    int n_tests = 0;
    int n_fail  = 0;

    core_dmem_ctrl #(
        .XLEN       (32),
        .DEPTH_WORDS(DEPTH),
        .MMIO_BASE  (MMIO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_addr   (addr),
        .i_data_wr_data(wd),
        .i_data_mask   (mask),
        .i_data_wr_en  (we),
        .i_data_req    (req),
        .o_data_rd_data(rd_data),
        .o_data_ack    (ack),
        .o_misaligned  (mis),
        .o_tohost      (tohost),
        .o_tohost_valid(tohost_valid)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: byte-addressed memory and a plain 64-bit time counter.
    logic [7:0]  mem [int unsigned];
    logic [31:0] e_rd  = '0;
    logic [31:0] e_toh = '0;
    logic        e_ack = 1'b0;
    logic        e_mis = 1'b0;
    logic        e_tv  = 1'b0;
    logic [63:0] mt    = '0;

    always @(posedge clk or negedge rst_n) begin : model
        int unsigned nbytes;
        logic        in_mmio;
        logic        bad;
        logic [31:0] moff;
        logic [63:0] nxt;
        if (!rst_n) begin
            e_rd  = '0;
            e_toh = '0;
            e_ack = 1'b0;
            e_mis = 1'b0;
            e_tv  = 1'b0;
            mt    = '0;
        end else begin
            nbytes  = (mask == 2'b00) ? 1 : (mask == 2'b01) ? 2 : 4;
            in_mmio = (addr >= MMIO) && (addr < MMIO + 32'd64);
            moff    = addr - MMIO;
            bad     = ((addr % nbytes) != 0) || (in_mmio && nbytes != 4);
            e_ack   = req;
            e_mis   = req && bad;
            e_rd    = '0;
            e_tv    = 1'b0;
            nxt     = mt + 64'd1;
            if (req && !bad) begin
                if (in_mmio) begin
                    if (we) begin
                        if (moff == 0) begin
                            e_toh = wd;
                            e_tv  = 1'b1;
                        end else if (moff == 4) begin
                            nxt = {mt[63:32], wd};
                        end else if (moff == 8) begin
                            nxt = {wd, mt[31:0]};
                        end
                    end else begin
                        e_rd = (moff == 0) ? e_toh : (moff == 4) ? mt[31:0] :
                               (moff == 8) ? mt[63:32] : 32'h0;
                    end
                end else begin
                    for (int i = 0; i < nbytes; i++) begin
                        if (we) mem[(addr + i) % BYTES] = wd[8*i +: 8];
                        else    e_rd[8*i +: 8] = mem[(addr + i) % BYTES];
                    end
                end
            end
            mt = nxt;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ack", {31'b0, ack}, {31'b0, e_ack});
            check("misaligned", {31'b0, mis}, {31'b0, e_mis});
            check("tohost", tohost, e_toh);
            check("tohost_valid", {31'b0, tohost_valid}, {31'b0, e_tv});
            if (e_ack) check("rd_data", rd_data, e_rd);
        end
    end

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m,
                       input logic w);
        addr = a;
        wd   = d;
        mask = m;
        we   = w;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        idle(2);
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_rd", rd_data, 32'h0);
        check("rst_tohost", tohost, 32'h0);
        check("rst_tv", {31'b0, tohost_valid}, 32'h0);
        check("rst_mis", {31'b0, mis}, 32'h0);
        rst_n = 1'b1;
        idle(1);

        put(32'h100, 32'hDEAD_BEEF, 2'b10, 1'b1);
        put(32'h100, 32'h0, 2'b10, 1'b0);
        check("lw_100", rd_data, 32'hDEAD_BEEF);
        check("lw_100_ack", {31'b0, ack}, 32'h1);

        put(32'h100, 32'h1122_3344, 2'b10, 1'b1);
        put(32'h103, 32'h0000_00AA, 2'b00, 1'b1);
        put(32'h100, 32'h0, 2'b10, 1'b0);
        check("sb_merge", rd_data, 32'hAA22_3344);
        put(32'h103, 32'h0, 2'b00, 1'b0);
        check("lb_103", rd_data, 32'h0000_00AA);
        put(32'h101, 32'h0, 2'b00, 1'b0);
        put(32'h102, 32'h0, 2'b01, 1'b0);

        put(32'h300, 32'hCAFE_BABE, 2'b10, 1'b1);
        put(32'h302, 32'h0, 2'b01, 1'b0);
        check("lh_302", rd_data, 32'h0000_CAFE);
        put(32'h301, 32'h0, 2'b01, 1'b0);
        check("lh_301_mis", {31'b0, mis}, 32'h1);
        check("lh_301_rd", rd_data, 32'h0);
        put(32'h302, 32'h5555_5555, 2'b10, 1'b1);
        put(32'h301, 32'h0000_7777, 2'b01, 1'b1);
        put(32'h300, 32'h0, 2'b11, 1'b0);
        check("lw_300_intact", rd_data, 32'hCAFE_BABE);
        put(32'h300, 32'h0000_0042, 2'b00, 1'b1);
        put(32'h300, 32'h0, 2'b10, 1'b0);
        check("sb_300", rd_data, 32'hCAFE_BA42);

        put(MMIO, 32'h1, 2'b10, 1'b1);
        check("tohost_set", tohost, 32'h1);
        check("tohost_pulse", {31'b0, tohost_valid}, 32'h1);
        idle(1);
        check("tohost_pulse_end", {31'b0, tohost_valid}, 32'h0);
        put(MMIO, 32'h7, 2'b00, 1'b1);
        put(MMIO, 32'h0, 2'b10, 1'b0);
        check("tohost_rd", rd_data, 32'h1);
        put(MMIO + 32'h10, 32'h9, 2'b10, 1'b1);
        put(MMIO + 32'h10, 32'h0, 2'b10, 1'b0);

        put(MMIO + 32'h4, 32'hFFFF_FFFE, 2'b10, 1'b1);
        put(MMIO + 32'h8, 32'h0, 2'b10, 1'b1);
        idle(3);
        put(MMIO + 32'h8, 32'h0, 2'b10, 1'b0);
        check("mtime_hi", rd_data, 32'h1);
        put(MMIO + 32'h4, 32'h0, 2'b10, 1'b0);
        check("mtime_lo", rd_data, 32'h2);

        put(32'h100 + BYTES, 32'h1234_5678, 2'b10, 1'b1);
        put(32'h104, 32'h0BAD_F00D, 2'b10, 1'b1);
        put(32'h100, 32'h0, 2'b10, 1'b0);
        check("alias", rd_data, 32'h1234_5678);
        put(32'h100, 32'h0, 2'b10, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'b0, ack}, 32'h0);
        check("midrst_rd", rd_data, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        put(32'h100, 32'h0, 2'b10, 1'b0);
        check("post_rst_100", rd_data, 32'h1234_5678);
        put(32'h104, 32'h0, 2'b10, 1'b0);
        check("post_rst_104", rd_data, 32'h0BAD_F00D);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
